// File: rtl/pkwars_pkg.sv
// Shared types and constants for the Penguin-Kun Wars download sequencer.
package pkwars_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } ld_state_t;

    localparam logic [7:0] PK_ROM_IDX = 8'd0;
    localparam logic [7:0] PK_DSW_IDX = 8'd254;
    localparam int         CNT_W      = 18;

    // Byte counter sticks at all-ones so an oversized stream cannot wrap back to a valid length.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pkwars_rst_timer.sv
// Loadable down-counter with zero flag; times the core reset hold window.
module pkwars_rst_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pkwars_rom_loader.sv
// Steers the ioctl download onto the core ROM port, captures DIP bytes,
// validates the image length and owns the game core reset.
module pkwars_rom_loader
    import pkwars_pkg::*;
#(
    parameter logic [16:0] ROM_LEN  = 17'h18000,
    parameter logic [15:0] RST_HOLD = 16'd4800,
    parameter logic [7:0]  ROM_IDX  = PK_ROM_IDX,
    parameter logic [7:0]  DSW_IDX  = PK_DSW_IDX
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        reset_req,
    output logic        rom_we,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);

    ld_state_t        r_state;
    logic             r_dl_prev;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_rom_we;
    logic [16:0]      r_rom_addr;
    logic [7:0]       r_rom_data;
    logic             r_core_reset;
    logic             r_load_done;
    logic             r_load_error;

    logic w_dl_rise;
    logic w_dl_fall;
    logic w_rom_start;
    logic w_rom_wr;
    logic w_dsw_wr;
    logic w_in_range;
    logic w_len_ok;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_zero;

    assign w_dl_rise   = ioctl_download & ~r_dl_prev;
    assign w_dl_fall   = ~ioctl_download & r_dl_prev;
    assign w_rom_start = w_dl_rise && (ioctl_index == ROM_IDX);
    assign w_rom_wr    = ioctl_wr && (ioctl_index == ROM_IDX);
    assign w_dsw_wr    = ioctl_wr && (ioctl_index == DSW_IDX) && (ioctl_addr[24:3] == '0);
    assign w_in_range  = (ioctl_addr < {8'd0, ROM_LEN});
    assign w_len_ok    = (r_count == {1'b0, ROM_LEN}) && !r_overflow;

    // A held reset_req keeps reloading the window, so counting starts only on release.
    assign w_tmr_load = ((r_state == ST_CHECK) && w_len_ok) ||
                        (((r_state == ST_RUN) || (r_state == ST_HOLD)) && reset_req);
    assign w_tmr_dec  = (r_state == ST_HOLD) && !reset_req;

    pkwars_rst_timer #(
        .W (16)
    ) u_rst_timer (
        .i_clk      (clk_sys),
        .i_rst_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (RST_HOLD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_dl_prev    <= 1'b0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_data   <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_rom_we  <= 1'b0;
            if (w_rom_start) begin
                r_state      <= ST_LOAD;
                r_count      <= '0;
                r_overflow   <= 1'b0;
                r_load_done  <= 1'b0;
                r_load_error <= 1'b0;
                r_core_reset <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_core_reset <= 1'b1;
                    end
                    ST_LOAD: begin
                        r_core_reset <= 1'b1;
                        // A strobe coinciding with the falling download edge is still taken.
                        if (w_rom_wr) begin
                            if (w_in_range) begin
                                r_rom_we   <= 1'b1;
                                r_rom_addr <= ioctl_addr[16:0];
                                r_rom_data <= ioctl_dout;
                                r_count    <= sat_inc(r_count);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (w_dl_fall) begin
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (w_len_ok) begin
                            r_state     <= ST_HOLD;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!reset_req && w_tmr_zero) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (reset_req) begin
                            r_state      <= ST_HOLD;
                            r_core_reset <= 1'b1;
                        end
                    end
                    ST_ERROR: begin
                        r_core_reset <= 1'b1;
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    // DIP bytes are written independently of the sequencer, one register per byte lane.
    for (genvar gi = 0; gi < 8; gi++) begin : g_dsw
        logic [7:0] r_byte;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_byte <= '0;
            end else if (w_dsw_wr && (ioctl_addr[2:0] == 3'(gi))) begin
                r_byte <= ioctl_dout;
            end
        end

        assign dsw[8*gi +: 8] = r_byte;
    end

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

endmodule

// File: tb/tb_pkwars_rom_loader.sv
// Scoreboard bench for pkwars_rom_loader with a shortened image and hold window.
module tb_pkwars_rom_loader;
    import pkwars_pkg::*;

    localparam logic [16:0] ROM_LEN  = 17'h100;
    localparam logic [15:0] RST_HOLD = 16'd100;
    localparam int          N        = 256;
    localparam int          HOLD     = 100;

    logic        clk_sys        = 1'b0;
    logic        reset_n        = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
    logic [7:0]  ioctl_index    = '0;
    logic        reset_req      = 1'b0;
    logic        rom_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [63:0] dsw;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    pkwars_rom_loader #(
        .ROM_LEN  (ROM_LEN),
        .RST_HOLD (RST_HOLD),
        .ROM_IDX  (8'd0),
        .DSW_IDX  (8'd254)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .reset_req      (reset_req),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          due;
    } rom_exp_t;

    rom_exp_t exp_q[$];
    rom_exp_t mon_e;
    int n_errors   = 0;
    int n_checks   = 0;
    int rom_we_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && (rom_we === 1'b1)) begin
            rom_we_cnt++;
            if (exp_q.size() == 0) begin
                chk("rom_we_unexpected", {63'd0, rom_we}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rom_addr", {47'd0, rom_addr}, {47'd0, mon_e.addr});
                chk("rom_data", {56'd0, rom_data}, {56'd0, mon_e.data});
                chk("rom_latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Streams nbytes at linear addresses; the last strobe shares its cycle with the download fall.
    task automatic do_download(input logic [7:0] idx, input int nbytes, output int fall_cyc);
        rom_we_cnt     = 0;
        fall_cyc       = -1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < nbytes; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom_range(0, 255));
            if ((idx == 8'd0) && (i < N))
                exp_q.push_back('{17'(i), ioctl_dout, cyc + 1});
            if (i == nbytes - 1) begin
                ioctl_download = 1'b0;
                fall_cyc       = cyc;
            end
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        $display("download idx=%0d bytes=%0d fall_cyc=%0d", idx, nbytes, fall_cyc);
    endtask

    task automatic wait_run(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_sys);
            if (core_reset === 1'b0) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic dip_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        $display("write idx=%0d addr=%0d data=0x%02h", idx, a, d);
    endtask

    initial begin
        int fall_c;
        int run_c;
        int low_cnt;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
        chk("rst_load_done", {63'd0, load_done}, 64'd0);
        chk("rst_load_error", {63'd0, load_error}, 64'd0);
        chk("rst_rom_we", {63'd0, rom_we}, 64'd0);
        chk("rst_rom_addr", {47'd0, rom_addr}, 64'd0);
        chk("rst_rom_data", {56'd0, rom_data}, 64'd0);
        chk("rst_dsw", dsw, 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_core_reset", {63'd0, core_reset}, 64'd1);

        // Good load: fall seen at the edge after fall_c, release RST_HOLD+2 edges after that.
        do_download(8'd0, N, fall_c);
        chk("good_load_done", {63'd0, load_done}, 64'd1);
        chk("good_load_error", {63'd0, load_error}, 64'd0);
        wait_run(HOLD + 20, run_c);
        chk("good_release_cycle", 64'(run_c), 64'(fall_c + 1 + HOLD + 2));
        chk("good_we_count", 64'(rom_we_cnt), 64'(N));
        chk("good_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("good_state_run", 64'(dut.r_state), 64'(ST_RUN));

        // DIP capture while running, including ignored address and index.
        ioctl_download = 1'b1;
        dip_write(8'd254, 25'd0, 8'hA5);
        chk("dip_byte0_latency", {56'd0, dsw[7:0]}, 64'hA5);
        dip_write(8'd254, 25'd7, 8'h3C);
        dip_write(8'd254, 25'd8, 8'hFF);
        dip_write(8'd5, 25'd1, 8'h77);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("dip_byte0", {56'd0, dsw[7:0]}, 64'hA5);
        chk("dip_byte7", {56'd0, dsw[63:56]}, 64'h3C);
        chk("dip_whole", dsw, 64'h3C00_0000_0000_00A5);
        chk("dip_core_reset", {63'd0, core_reset}, 64'd0);
        chk("dip_state_run", 64'(dut.r_state), 64'(ST_RUN));

        // User reset for 50 cycles.
        reset_req = 1'b1;
        tick();
        chk("ureq_core_reset_next", {63'd0, core_reset}, 64'd1);
        for (int k = 0; k < 49; k++) tick();
        chk("ureq_core_reset_held", {63'd0, core_reset}, 64'd1);
        reset_req = 1'b0;
        fall_c    = cyc;
        $display("reset_req released at cyc=%0d", fall_c);
        wait_run(HOLD + 20, run_c);
        chk("ureq_release_cycle", 64'(run_c), 64'(fall_c + 1 + HOLD));

        // Short load lands in ERROR and holds the core.
        do_download(8'd0, N - 1, fall_c);
        tick();
        chk("short_load_error", {63'd0, load_error}, 64'd1);
        chk("short_load_done", {63'd0, load_done}, 64'd0);
        chk("short_state", 64'(dut.r_state), 64'(ST_ERROR));
        chk("short_we_count", 64'(rom_we_cnt), 64'(N - 1));
        low_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_sys);
            if (core_reset !== 1'b1) low_cnt++;
        end
        chk("short_reset_low_cycles", 64'(low_cnt), 64'd0);

        // Oversize load: the out-of-range byte is dropped, image rejected.
        do_download(8'd0, N + 1, fall_c);
        tick();
        chk("over_we_count", 64'(rom_we_cnt), 64'(N));
        chk("over_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("over_state", 64'(dut.r_state), 64'(ST_ERROR));
        chk("over_load_error", {63'd0, load_error}, 64'd1);
        chk("over_load_done", {63'd0, load_done}, 64'd0);
        chk("over_core_reset", {63'd0, core_reset}, 64'd1);

        // Good load from ERROR, then restart while the hold window runs.
        do_download(8'd0, N, fall_c);
        for (int k = 0; k < 10; k++) tick();
        chk("hold_state", 64'(dut.r_state), 64'(ST_HOLD));
        chk("hold_load_done", {63'd0, load_done}, 64'd1);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        chk("reload_load_done", {63'd0, load_done}, 64'd0);
        chk("reload_core_reset", {63'd0, core_reset}, 64'd1);
        chk("reload_state", 64'(dut.r_state), 64'(ST_LOAD));
        do_download(8'd0, N, fall_c);
        wait_run(HOLD + 20, run_c);
        chk("reload_release_cycle", 64'(run_c), 64'(fall_c + 1 + HOLD + 2));
        chk("reload_we_count", 64'(rom_we_cnt), 64'(N));
        chk("reload_load_done_end", {63'd0, load_done}, 64'd1);

        // Asynchronous reset in the middle of a download.
        rom_we_cnt     = 0;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom_range(0, 255));
            exp_q.push_back('{17'(i), ioctl_dout, cyc + 1});
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        tick();
        #2 reset_n = 1'b0;
        #1;
        $display("async reset asserted at cyc=%0d", cyc);
        chk("areset_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("areset_core_reset", {63'd0, core_reset}, 64'd1);
        chk("areset_load_done", {63'd0, load_done}, 64'd0);
        chk("areset_we_count", 64'(rom_we_cnt), 64'd5);
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("areset_after_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("areset_after_core_reset", {63'd0, core_reset}, 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
